// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//   Steps an NCO phase increment from cfg_start towards cfg_stop in cfg_step
//   increments. Each increment value is held for cfg_dwell+1 clk_en pulses.
//   clk_en pulses once every cfg_prescale+1 cycles while sweeping. A sweep
//   either ends with a one-cycle done pulse (single mode) or restarts from
//   cfg_start forever (continuous mode) until abort.
//
// Ports
//   clock           : single clock, all logic on posedge
//   reset           : synchronous, active-high reset
//   cfg_valid       : configuration word valid
//   cfg_ready       : configuration accepted (high only in IDLE)
//   cfg_start       : first increment of a segment
//   cfg_stop        : highest increment allowed in a segment
//   cfg_step        : increment added after every dwell
//   cfg_dwell       : number of extra clk_en pulses per increment value
//   cfg_prescale    : number of idle cycles between clk_en pulses
//   cfg_cont        : 1 = continuous sweep, 0 = single sweep ending in done
//   start           : begin a sweep (needs a loaded configuration)
//   abort           : terminate the sweep immediately, no done pulse
//   phase_increment : value driven to the NCO phase_increment input
//   clk_en          : value driven to the NCO clk_en input
//   busy            : high whenever the controller is not idle
//   done            : one-cycle pulse at normal sweep completion
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         cfg_start,
  input  logic [7:0]         cfg_stop,
  input  logic [7:0]         cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [7:0]         cfg_prescale,
  input  logic               cfg_cont,
  input  logic               start,
  input  logic               abort,
  output logic [7:0]         phase_increment,
  output logic               clk_en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         pi_q, pi_d;
  logic               clk_en_q, clk_en_d;
  logic               done_q, done_d;
  logic [7:0]         presc_q, presc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [8:0]         sum;

  // Registered configuration
  logic               loaded_q;
  logic [7:0]         start_q, stop_q, step_q, prescale_q;
  logic [DWELL_W-1:0] dwell_cfg_q;
  logic               cont_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      loaded_q    <= 1'b0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      prescale_q  <= '0;
      dwell_cfg_q <= '0;
      cont_q      <= 1'b0;
    end else if (cfg_valid && (state_q == IDLE)) begin
      loaded_q    <= 1'b1;
      start_q     <= cfg_start;
      stop_q      <= cfg_stop;
      step_q      <= cfg_step;
      prescale_q  <= cfg_prescale;
      dwell_cfg_q <= cfg_dwell;
      cont_q      <= cfg_cont;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pi_q     <= '0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      pi_q     <= pi_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      presc_q  <= presc_d;
      dwell_q  <= dwell_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pi_d     = pi_q;
    clk_en_d = 1'b0;
    done_d   = 1'b0;
    presc_d  = presc_q;
    dwell_d  = dwell_q;
    // 9-bit sum so a carry out of the 8-bit increment ends the segment
    sum      = {1'b0, pi_q} + {1'b0, step_q};

    case (state_q)
      IDLE: begin
        pi_d    = '0;
        presc_d = '0;
        dwell_d = '0;
        if (start && loaded_q && !abort) begin
          state_d  = RUN;
          pi_d     = start_q;
          clk_en_d = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          // The pulse that would have followed is dropped along with the sweep
          state_d = IDLE;
          pi_d    = '0;
          presc_d = '0;
          dwell_d = '0;
        end else begin
          // presc_q counts cycles since the last pulse
          if (presc_q == prescale_q) begin
            presc_d  = '0;
            clk_en_d = 1'b1;
          end else begin
            presc_d = presc_q + 8'd1;
          end

          // Increment decisions are taken on pulse cycles so the new value
          // is in place before the next pulse
          if (clk_en_q) begin
            if (dwell_q == dwell_cfg_q) begin
              dwell_d = '0;
              if ((sum <= {1'b0, stop_q}) && (step_q != 8'd0)) begin
                pi_d = sum[7:0];
              end else if (cont_q) begin
                pi_d = start_q;
              end else begin
                state_d  = DONE;
                clk_en_d = 1'b0;
                done_d   = 1'b1;
                presc_d  = '0;
              end
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        pi_d    = '0;
        presc_d = '0;
        dwell_d = '0;
      end

      default: begin
        state_d = IDLE;
        pi_d    = '0;
        presc_d = '0;
        dwell_d = '0;
      end
    endcase
  end

  assign phase_increment = pi_q;
  assign clk_en          = clk_en_q;
  assign done            = done_q;
  assign busy            = (state_q != IDLE);
  assign cfg_ready       = (state_q == IDLE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_sweep_ctrl
//   Drives directed and randomized sweeps into nco_sweep_ctrl and compares the
//   per-cycle clk_en/busy/done/cfg_ready and the pulse-time phase_increment
//   against a list-based model of the sweep: the list of increment values is
//   built arithmetically from the configuration, and pulse times follow from
//   the prescale period.
// -----------------------------------------------------------------------------
module tb_nco_sweep_ctrl;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_start, cfg_stop, cfg_step, cfg_prescale;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_cont;
  logic          start, abort;
  logic [7:0]    phase_increment;
  logic          clk_en, busy, done;

  int total = 0;
  int bad   = 0;

  // Model copy of the configuration the DUT is expected to hold
  int m_start, m_stop, m_step, m_dwell, m_pre;
  bit m_cont;
  int vals[$];

  always #5 clock = ~clock;

  nco_sweep_ctrl #(.DWELL_W(DW)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_prescale(cfg_prescale), .cfg_cont(cfg_cont),
    .start(start), .abort(abort),
    .phase_increment(phase_increment), .clk_en(clk_en),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_cfg(input int s, input int e, input int st,
                          input int d, input int p, input bit c);
    m_start = s; m_stop = e; m_step = st; m_dwell = d; m_pre = p; m_cont = c;
    cfg_start    = s[7:0];
    cfg_stop     = e[7:0];
    cfg_step     = st[7:0];
    cfg_dwell    = d[DW-1:0];
    cfg_prescale = p[7:0];
    cfg_cont     = c;
    cfg_valid    = 1'b1;
    tick();
    cfg_valid    = 1'b0;
  endtask

  // Increment values of one segment: start, start+step, ... while <= stop
  function automatic void build_vals();
    int v;
    vals.delete();
    v = m_start;
    vals.push_back(v);
    while (m_step != 0 && (v + m_step) <= m_stop) begin
      v = v + m_step;
      vals.push_back(v);
    end
  endfunction

  // Start a sweep and check it cycle by cycle. Single sweeps are followed
  // through DONE into IDLE; continuous sweeps are checked for ncyc cycles.
  // junk=1 hammers cfg_valid with random words while the sweep runs.
  task automatic run_check(input string tag, input bit junk, input int ncyc);
    int  per, tp, lastc, k, exp_pi;
    bit  pulse;
    logic [3:0] exp_v;
    build_vals();
    per = m_pre + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (junk) begin
      cfg_valid    = 1'b1;
      cfg_start    = 8'($urandom);
      cfg_stop     = 8'($urandom);
      cfg_step     = 8'($urandom);
      cfg_dwell    = 16'($urandom);
      cfg_prescale = 8'($urandom);
      cfg_cont     = 1'($urandom);
    end
    if (!m_cont) begin
      tp    = vals.size() * (m_dwell + 1);
      lastc = 1 + (tp - 1) * per;
    end else begin
      lastc = ncyc;
    end
    for (int c = 1; c <= lastc; c++) begin
      pulse = (((c - 1) % per) == 0);
      exp_v = {1'b1, pulse, 1'b0, 1'b0};
      total++;
      if ({busy, clk_en, done, cfg_ready} !== exp_v) begin
        bad++;
        $display("FAIL %s ctl cycle=%0d got busy/clk_en/done/ready=%b want=%b",
                 tag, c, {busy, clk_en, done, cfg_ready}, exp_v);
      end
      if (pulse) begin
        k = ((c - 1) / per) / (m_dwell + 1);
        if (m_cont) k = k % vals.size();
        exp_pi = (k < vals.size()) ? vals[k] : -1;
        total++;
        if (int'(phase_increment) != exp_pi) begin
          bad++;
          $display("FAIL %s pi cycle=%0d got=%0d want=%0d",
                   tag, c, phase_increment, exp_pi);
        end
      end
      tick();
    end
    cfg_valid = 1'b0;
    if (!m_cont) begin
      total++;
      if ({busy, clk_en, done, cfg_ready} !== 4'b1010 ||
          int'(phase_increment) != vals[vals.size() - 1]) begin
        bad++;
        $display("FAIL %s done_cycle got ctl=%b pi=%0d want ctl=1010 pi=%0d",
                 tag, {busy, clk_en, done, cfg_ready}, phase_increment,
                 vals[vals.size() - 1]);
      end
      tick();
      total++;
      if ({busy, clk_en, done, cfg_ready} !== 4'b0001 || phase_increment !== 8'd0) begin
        bad++;
        $display("FAIL %s idle_after got ctl=%b pi=%0d want ctl=0001 pi=0",
                 tag, {busy, clk_en, done, cfg_ready}, phase_increment);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if ({busy, clk_en, done, cfg_ready} !== 4'b0001 || phase_increment !== 8'd0) begin
      bad++;
      $display("FAIL %s got ctl=%b pi=%0d want ctl=0001 pi=0",
               tag, {busy, clk_en, done, cfg_ready}, phase_increment);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, clk_en, done} !== 3'b000 || phase_increment !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got ctl=%b pi=%0d want ctl=000 pi=0",
               {busy, clk_en, done}, phase_increment);
    end
    reset = 1'b0;
    tick();
    check_idle("reset_release");
  endtask

  task automatic test_start_no_cfg();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("start_no_cfg");
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    load_cfg(10, 30, 10, 1, 0, 1'b0);
    run_check("basic", 1'b0, 0);
  endtask

  task automatic test_prescale();
    load_cfg(10, 30, 10, 1, 2, 1'b0);
    run_check("prescale", 1'b0, 0);
  endtask

  task automatic test_cont_carry();
    load_cfg(250, 255, 4, 0, 0, 1'b1);
    run_check("cont_carry", 1'b0, 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("cont_abort");
  endtask

  task automatic test_abort();
    load_cfg(10, 30, 10, 1, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // now in RUN cycle 3
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_next");
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet got done=%b busy=%b want done=0 busy=0", done, busy);
      end
    end
    run_check("abort_rerun", 1'b0, 0);
    // abort wins over start in the same IDLE cycle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_vs_start");
  endtask

  task automatic test_step0_cfg_locked();
    load_cfg(7, 7, 0, 2, 0, 1'b0);
    run_check("step0_junk", 1'b1, 0);
    run_check("step0_rerun", 1'b0, 0);
  endtask

  task automatic test_random();
    int s, e, st, d, p;
    for (int n = 0; n < 15; n++) begin
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 255);
      d  = $urandom_range(0, 2);
      p  = $urandom_range(0, 3);
      load_cfg(s, e, st, d, p, 1'b0);
      run_check("random", 1'b0, 0);
    end
    load_cfg($urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(16, 255), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    run_check("random_cont", 1'b0, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("random_cont_abort");
  endtask

  task automatic test_reset_midrun();
    load_cfg(10, 30, 10, 1, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("reset_midrun");
    // configuration is forgotten, so start alone does nothing
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("reset_clears_cfg");
  endtask

  initial begin
    reset        = 1'b1;
    cfg_valid    = 1'b0;
    cfg_start    = '0;
    cfg_stop     = '0;
    cfg_step     = '0;
    cfg_dwell    = '0;
    cfg_prescale = '0;
    cfg_cont     = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;

    test_reset();
    test_start_no_cfg();
    test_basic();
    test_prescale();
    test_cont_carry();
    test_abort();
    test_step0_cfg_locked();
    test_random();
    test_reset_midrun();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
